// File: rtl/asconp_pkg.sv
// asconp_pkg: shared Ascon-p tables, round constant helper and types
package asconp_pkg;
  typedef logic [31:0][4:0] sbox_t;
  typedef logic [4:0][5:0] rot_t;
  typedef struct packed {
    logic [63:0] x0;
    logic [63:0] x1;
    logic [63:0] x2;
    logic [63:0] x3;
    logic [63:0] x4;
  } state_t;
  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_e;
  localparam sbox_t SBOX = {
    5'h17, 5'h0f, 5'h0a, 5'h16, 5'h19, 5'h01, 5'h0c, 5'h10,
    5'h18, 5'h11, 5'h0d, 5'h00, 5'h0e, 5'h07, 5'h13, 5'h1e,
    5'h1c, 5'h06, 5'h03, 5'h1d, 5'h12, 5'h08, 5'h05, 5'h1b,
    5'h02, 5'h09, 5'h15, 5'h1a, 5'h14, 5'h1f, 5'h0b, 5'h04
  };
  function automatic sbox_t inv_sbox(input sbox_t s);
    sbox_t t;
    t = '0;
    for (int i = 0; i < 32; i++) t[s[i]] = 5'(i);
    return t;
  endfunction
  localparam sbox_t SBOX_INV = inv_sbox(SBOX);
  localparam rot_t ROT_A = {6'd7, 6'd10, 6'd1, 6'd61, 6'd19};
  localparam rot_t ROT_B = {6'd41, 6'd17, 6'd6, 6'd39, 6'd28};
  function automatic logic [7:0] rc(input logic [3:0] r);
    return {4'hF - r, r};
  endfunction
endpackage

// File: rtl/asconp_inv_iter_round.sv
// asconp_inv_round: one combinational inverse Ascon round (L^-1, S^-1, constant)
module asconp_inv_round
  import asconp_pkg::*;
(
  input  logic       en,
  input  logic [3:0] r,
  input  state_t     state_i,
  output state_t     state_o
);
  function automatic logic [63:0] ror(input logic [63:0] v, input logic [5:0] s);
    logic [127:0] d;
    d = {v, v} >> s;
    return d[63:0];
  endfunction
  // (1+x^a+x^b)^63 expands to a product of six sparse factors with doubled exponents
  function automatic logic [63:0] lin_inv(input logic [63:0] v, input logic [5:0] a, input logic [5:0] b);
    logic [63:0] y;
    y = v;
    for (int k = 0; k < 6; k++) y = y ^ ror(y, 6'(a << k)) ^ ror(y, 6'(b << k));
    return y;
  endfunction
  logic [4:0][63:0] w, l, s;
  logic [4:0] col;
  // undo the linear layer, then the S-box column by column, then the constant
  always_comb begin
    w = {state_i.x4, state_i.x3, state_i.x2, state_i.x1, state_i.x0};
    l = '0;
    s = '0;
    col = '0;
    for (int i = 0; i < 5; i++) l[i] = lin_inv(w[i], ROT_A[i], ROT_B[i]);
    for (int c = 0; c < 64; c++) begin
      col = SBOX_INV[{l[0][c], l[1][c], l[2][c], l[3][c], l[4][c]}];
      for (int i = 0; i < 5; i++) s[i][c] = col[4-i];
    end
    s[2][7:0] = s[2][7:0] ^ rc(r);
    state_o = en ? {s[0], s[1], s[2], s[3], s[4]} : state_i;
  end
endmodule

// File: rtl/asconp_inv_iter.sv
// asconp_inv_iter: iterative inverse Ascon permutation with valid/ready handshakes
module asconp_inv_iter
  import asconp_pkg::*;
#(
  parameter int UROL = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  rounds_i,
  input  logic [63:0] x0_i,
  input  logic [63:0] x1_i,
  input  logic [63:0] x2_i,
  input  logic [63:0] x3_i,
  input  logic [63:0] x4_i,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] x0_o,
  output logic [63:0] x1_o,
  output logic [63:0] x2_o,
  output logic [63:0] x3_o,
  output logic [63:0] x4_o
);
  fsm_e fsm_q, fsm_d;
  state_t state_q, state_d;
  logic signed [4:0] r_idx_q, r_idx_d, stop_idx_q, stop_idx_d, r_next;
  logic [3:0] n;
  state_t chain [UROL+1];
  assign n = rounds_i > 4'd12 ? 4'd12 : rounds_i;
  assign r_next = r_idx_q - 5'(UROL);
  assign chain[0] = state_q;
  for (genvar j = 0; j < UROL; j++) begin : g_slot
    logic signed [4:0] ri;
    assign ri = r_idx_q - 5'(j);
    asconp_inv_round u_round (
      .en(ri >= stop_idx_q),
      .r(ri[3:0]),
      .state_i(chain[j]),
      .state_o(chain[j+1])
    );
  end
  // accept in IDLE, peel UROL rounds per cycle in RUN, hold the result in DONE
  always_comb begin
    fsm_d = fsm_q;
    state_d = state_q;
    r_idx_d = r_idx_q;
    stop_idx_d = stop_idx_q;
    if (fsm_q == IDLE && in_valid) begin
      state_d = {x0_i, x1_i, x2_i, x3_i, x4_i};
      r_idx_d = 5'sd11;
      stop_idx_d = 5'd12 - {1'b0, n};
      fsm_d = n == 4'd0 ? DONE : RUN;
    end else if (fsm_q == RUN) begin
      state_d = chain[UROL];
      r_idx_d = r_next;
      fsm_d = r_next < stop_idx_q ? DONE : RUN;
    end else if (fsm_q == DONE && out_ready) begin
      fsm_d = IDLE;
    end
  end
  // state register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q <= IDLE;
      state_q <= '0;
      r_idx_q <= '0;
      stop_idx_q <= '0;
    end else begin
      fsm_q <= fsm_d;
      state_q <= state_d;
      r_idx_q <= r_idx_d;
      stop_idx_q <= stop_idx_d;
    end
  end
  assign in_ready = fsm_q == IDLE;
  assign out_valid = fsm_q == DONE;
  assign x0_o = state_q.x0;
  assign x1_o = state_q.x1;
  assign x2_o = state_q.x2;
  assign x3_o = state_q.x3;
  assign x4_o = state_q.x4;
endmodule

// File: tb/tb_asconp_inv_iter.sv
// tb_asconp_inv_iter: round-trip bench driving UROL=1,2,3 instances against a forward Ascon-p model
module tb_asconp_inv_iter;
  typedef logic [63:0] st_t [5];
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic [3:0] rounds = 0;
  logic [63:0] xi [5];
  logic [2:0] in_ready, out_valid;
  logic [63:0] xo [3][5];
  int checks = 0, errors = 0;
  logic [63:0] exp_x [5];
  int exp_lat [3];
  logic [2:0] seen = '0;
  time t_acc = 0;
  always #5 clk = ~clk;
  for (genvar u = 0; u < 3; u++) begin : g_dut
    asconp_inv_iter #(.UROL(u + 1)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[u]),
      .rounds_i(rounds),
      .x0_i(xi[0]), .x1_i(xi[1]), .x2_i(xi[2]), .x3_i(xi[3]), .x4_i(xi[4]),
      .out_valid(out_valid[u]), .out_ready(out_ready),
      .x0_o(xo[u][0]), .x1_o(xo[u][1]), .x2_o(xo[u][2]), .x3_o(xo[u][3]), .x4_o(xo[u][4])
    );
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic logic [63:0] ror(input logic [63:0] v, input int s);
    return (v >> s) | (v << (64 - s));
  endfunction
  function automatic logic [63:0] lin(input logic [63:0] v, input int i);
    int a [5] = '{19, 61, 1, 10, 7};
    int b [5] = '{28, 39, 6, 17, 41};
    return v ^ ror(v, a[i]) ^ ror(v, b[i]);
  endfunction
  function automatic st_t sl(input st_t x);
    logic [63:0] t [5];
    x[0] ^= x[4]; x[4] ^= x[3]; x[2] ^= x[1];
    for (int i = 0; i < 5; i++) t[i] = ~x[i] & x[(i + 1) % 5];
    for (int i = 0; i < 5; i++) x[i] ^= t[(i + 1) % 5];
    x[1] ^= x[0]; x[0] ^= x[4]; x[3] ^= x[2]; x[2] = ~x[2];
    return x;
  endfunction
  function automatic logic [4:0] sbox5(input logic [4:0] v);
    st_t x;
    for (int i = 0; i < 5; i++) x[i] = {63'd0, v[4 - i]};
    x = sl(x);
    return {x[0][0], x[1][0], x[2][0], x[3][0], x[4][0]};
  endfunction
  function automatic st_t perm(input st_t x, input int n);
    for (int r = 12 - n; r < 12; r++) begin
      x[2] ^= 64'(240 - 15 * r);
      x = sl(x);
      for (int i = 0; i < 5; i++) x[i] = lin(x[i], i);
    end
    return x;
  endfunction
  function automatic st_t rnd_st();
    st_t x;
    for (int i = 0; i < 5; i++) x[i] = {$urandom, $urandom};
    return x;
  endfunction
  // every cycle a result is presented: data must be the original state, in_ready low, latency exact
  always @(negedge clk) begin
    if (!rst) begin
      for (int u = 0; u < 3; u++) begin
        if (out_valid[u]) begin
          if (!seen[u]) chk($sformatf("latency_u%0d", u + 1), 64'(($time - t_acc - 5) / 10), 64'(exp_lat[u]));
          seen[u] = 1'b1;
          chk($sformatf("in_ready_done_u%0d", u + 1), 64'(in_ready[u]), 64'd0);
          for (int i = 0; i < 5; i++) chk($sformatf("data_u%0d_x%0d", u + 1, i), xo[u][i], exp_x[i]);
        end
      end
    end
  end
  task automatic start_job(input st_t s, input int n_in);
    int n;
    n = n_in > 12 ? 12 : n_in;
    @(negedge clk);
    chk("in_ready_idle", 64'(in_ready), 64'h7);
    exp_x = s;
    xi = perm(s, n);
    rounds = 4'(n_in);
    in_valid = 1;
    out_ready = 0;
    seen = '0;
    for (int u = 0; u < 3; u++) exp_lat[u] = n == 0 ? 0 : (n + u) / (u + 1);
    @(posedge clk);
    t_acc = $time;
    @(negedge clk);
    in_valid = 0;
  endtask
  task automatic run_job(input st_t s, input int n_in, input int hold);
    start_job(s, n_in);
    for (int c = 0; c < 20 && seen != 3'b111; c++) @(negedge clk);
    for (int u = 0; u < 3; u++) chk($sformatf("done_u%0d", u + 1), 64'(seen[u]), 64'd1);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1;
      xi = rnd_st();
      rounds = 4'($urandom_range(0, 15));
      @(negedge clk);
    end
    out_ready = 1;
    @(negedge clk);
    in_valid = 0;
    out_ready = 0;
    chk("in_ready_after", 64'(in_ready), 64'h7);
    chk("out_valid_after", 64'(out_valid), 64'h0);
  endtask
  initial begin
    st_t s;
    for (int i = 0; i < 5; i++) xi[i] = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'h7);
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    for (int u = 0; u < 3; u++) chk($sformatf("rst_x0_u%0d", u + 1), xo[u][0] | xo[u][4], 64'd0);
    rst = 0;
    chk("pin_sigma0_1", lin(64'h1, 0), 64'h0000201000000001);
    chk("pin_sbox_00", 64'(sbox5(5'h00)), 64'h04);
    chk("pin_sbox_01", 64'(sbox5(5'h01)), 64'h0b);
    chk("pin_sbox_14", 64'(sbox5(5'h14)), 64'h00);
    chk("pin_sbox_1f", 64'(sbox5(5'h1f)), 64'h17);
    s = '{64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 64'h0, 64'hFFFFFFFFFFFFFFFF, 64'h8000000000000001};
    run_job(s, 12, 0);
    for (int k = 0; k < 4; k++) begin
      run_job(rnd_st(), 6, 0);
      run_job(rnd_st(), 8, 0);
    end
    run_job(rnd_st(), 0, 0);
    run_job(rnd_st(), 15, 0);
    run_job(rnd_st(), 13, 0);
    run_job(rnd_st(), 8, 5);
    start_job(rnd_st(), 12);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("midrst_in_ready", 64'(in_ready), 64'h7);
    chk("midrst_out_valid", 64'(out_valid), 64'h0);
    for (int u = 0; u < 3; u++)
      for (int i = 0; i < 5; i++) chk($sformatf("midrst_u%0d_x%0d", u + 1, i), xo[u][i], 64'd0);
    run_job(rnd_st(), 12, 0);
    for (int n = 0; n <= 12; n++) run_job(rnd_st(), n, n % 3);
    for (int k = 0; k < 100; k++) run_job(rnd_st(), 1, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end
endmodule
